rx_delay_line: RTL and testbench
================================

Name: rx_delay_line

Overview:
- Receive-side consumer of the per-element focusing delay produced by delay_calc.
- Stores one channel's incoming echo samples in a circular buffer.
- On each incoming sample, emits the sample received `delay` samples earlier, so delay-and-sum sees time-aligned channels.
- One instance per transducer element, between the ADC sample stream and the summation stage.

Parameters:
- SAMPLE_W, 16, echo sample width.
- DELAY_W, 8, delay width; equals the delay_calc delay_out width.
- DEPTH, 256, buffer entries; must equal 2**DELAY_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; named as the codebase names it.
- delay_in  in  DELAY_W  delay in samples; connects to delay_calc delay_out.
- delay_load  in  1  one-cycle strobe, connects to delay_calc done; latches delay_in.
- sample_in  in  SAMPLE_W  echo sample from ADC front end.
- sample_valid  in  1  sample_in valid this cycle.
- sample_out  out  SAMPLE_W  delayed sample.
- sample_out_valid  out  1  sample_out valid; one-cycle pulse per accepted input once aligned.
- debug_state  out  4  current FSM state, zero-extended.

Behaviour:
- Reset (reset low, async assert, sync release): wr_ptr=0, fill=0, delay_reg=0, state=IDLE. sample_out=0, sample_out_valid=0, debug_state=0. Buffer RAM is not cleared; `fill` gates all reads.
- Write path:
  - On sample_valid, write sample_in at wr_ptr, then increment wr_ptr mod DEPTH.
  - fill increments, saturating at DEPTH-1.
  - Writes occur in every state, including IDLE.
- Read address = (wr_ptr - delay_reg) mod DEPTH, computed with DELAY_W-bit wrap.
- delay 0 bypass: sample_out = sample_in of the same accepted cycle. No RAM read-during-write dependence.
- Latency: sample_out and sample_out_valid are registered and appear exactly 1 cycle after the accepted sample_valid.
- FSM states:
  - IDLE (0): no delay loaded. Outputs never valid.
  - FILL (1): delay loaded but fill < delay_reg. Outputs not valid.
  - RUN (2): fill >= delay_reg. Each accepted sample yields sample_out_valid=1 one cycle later.
- Transitions:
  - IDLE --delay_load--> FILL or RUN. Target is RUN if fill (counting this cycle's write) >= delay_in, else FILL.
  - FILL --fill reaches delay_reg--> RUN. The first valid output corresponds to the accepted input at which fill becomes >= delay_reg.
  - RUN --delay_load with delay_in <= fill--> stay in RUN. The new delay applies to the sample accepted in the same cycle, with no gap.
  - RUN --delay_load with delay_in > fill--> FILL.
  - delay_load is accepted in any state; the last load wins.
- Simultaneous delay_load and sample_valid: the sample is written and the new delay governs its read.
- delay_load without sample_valid: latches the delay only; no output.
- Wrap-around:
  - wr_ptr wraps 255->0 silently.
  - Maximum delay 255 < DEPTH, so a read never targets the slot currently being written.
- sample_valid gaps: no output during gaps. Delay is counted in accepted samples, not clock cycles.
- reset asserted mid-stream: all state is lost immediately. After release, the block waits in IDLE for a new delay_load.

Decomposition:
- Shared package ultrasound_bf_pkg holds:
  - SAMPLE_W and DELAY_W constants, shared with delay_calc.
  - The rx_delay_line state enum {IDLE=0, FILL=1, RUN=2}.
- Sub-module delay_ram: simple dual-port RAM, DEPTH x SAMPLE_W, one synchronous write port and one asynchronous read port. Infers block or distributed RAM.
- FSM, pointers, fill counter and output register live in rx_delay_line.

Test Plan:
1. Reset, then delay_load with delay_in=10; stream samples 1,2,3,... one per cycle.
   -> sample_out_valid first high 1 cycle after input 11 is accepted, with sample_out=1.
   -> Thereafter sample_out = input-10 each cycle. debug_state goes 1 then 2.
2. delay_in=0 loaded; stream 0xA5A5, 0x1234.
   -> Each sample appears 1 cycle later, valid from the first sample. State goes directly to RUN.
3. Running at delay 10 after 50 samples; delay_load with delay_in=3 in the same cycle as input 51.
   -> Next cycle sample_out=48, then 49, ... with no valid gap.
   -> A subsequent load of delay_in=200 at fill=60 drops valid and returns to FILL until fill reaches 200.
4. delay_in=255; stream 600 samples with ramp values mod 2^16.
   -> Across the wr_ptr wrap, every output equals input-255.
   -> sample_out_valid never asserts before 256 samples.
5. Delay 5, with sample_valid toggled 1,0,0,1,...
   -> Output count equals input count once in RUN. Delay is counted in accepted samples, not cycles.
6. reset driven low mid-RUN, asynchronously between clock edges.
   -> sample_out_valid and sample_out go to 0 immediately; debug_state=0.
   -> After release with no delay_load, no valid output for 100 inputs.

Source files
------------

// File: rtl/ultrasound_bf_pkg.sv
// Shared beamformer definitions: sample/delay widths common to delay_calc and
// rx_delay_line, and the rx_delay_line FSM state encoding.
package ultrasound_bf_pkg;

  localparam int SAMPLE_W = 16;
  localparam int DELAY_W  = 8;
  // The delay line holds every delay delay_calc can produce, so the buffer
  // depth is tied to the delay width rather than set independently.
  localparam int DEPTH    = 1 << DELAY_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_delay_line_if.sv
// Channel bundle between the ADC stream / delay_calc and one rx_delay_line.
//   delay_in, delay_load          : focusing delay and its one-cycle load strobe
//   sample_in, sample_valid       : incoming echo sample
//   sample_out, sample_out_valid  : time-aligned sample toward the summer
//   debug_state                   : current FSM state, zero-extended
// master = stimulus/upstream side, slave = the delay line.
interface rx_delay_line_if;
  import ultrasound_bf_pkg::*;

  logic [DELAY_W-1:0]  delay_in;
  logic                delay_load;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_out_valid;
  logic [3:0]          debug_state;

  modport master (
    output delay_in, delay_load, sample_in, sample_valid,
    input  sample_out, sample_out_valid, debug_state
  );

  modport slave (
    input  delay_in, delay_load, sample_in, sample_valid,
    output sample_out, sample_out_valid, debug_state
  );
endinterface

// File: rtl/delay_ram.sv
// Simple dual-port sample buffer: one synchronous write port, one
// asynchronous read port. Small enough to map to distributed RAM.
//   clk              : write clock
//   i_we/i_waddr/i_wdata : write port
//   i_raddr/o_rdata  : combinational read port
module delay_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [1 << ADDR_W];

  // NOTE: the array has no reset on purpose; a reset would prevent RAM
  // inference. Stale contents are never observed because the fill count
  // gates every read.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rx_delay_line.sv
// Per-element receive delay line. Each accepted echo sample is written into a
// circular buffer and, once enough history exists, the sample received
// `delay` accepted samples earlier is emitted one cycle later so that the
// delay-and-sum stage sees time-aligned channels.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rx_delay_line_if.slave (delay load, sample in, sample out, state)
module rx_delay_line
  import ultrasound_bf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  rx_delay_line_if.slave    bus
);

  localparam logic [DELAY_W-1:0] FILL_MAX = DELAY_W'(DEPTH - 1);

  rx_state_e           r_state;
  rx_state_e           w_state_next;
  logic [DELAY_W-1:0]  r_wr_ptr;
  logic [DELAY_W-1:0]  r_fill;
  logic [DELAY_W-1:0]  r_delay;
  logic [SAMPLE_W-1:0] r_out;
  logic                r_out_valid;

  logic [DELAY_W-1:0]  w_delay_eff;
  logic [DELAY_W-1:0]  w_fill_next;
  logic [DELAY_W-1:0]  w_rd_addr;
  logic [SAMPLE_W-1:0] w_rd_data;
  logic                w_armed;
  logic                w_out_valid;
  logic [SAMPLE_W-1:0] w_out_data;

  // A delay loaded this cycle already governs this cycle's sample.
  assign w_delay_eff = bus.delay_load ? bus.delay_in : r_delay;
  assign w_armed     = (r_state != IDLE) || bus.delay_load;
  assign w_fill_next = (bus.sample_valid && (r_fill != FILL_MAX))
                       ? r_fill + DELAY_W'(1) : r_fill;
  // Wraps naturally in DELAY_W bits; delay <= DEPTH-1 keeps it off the
  // slot being written this cycle.
  assign w_rd_addr   = r_wr_ptr - w_delay_eff;

  // r_fill counts samples stored before this one, so it must cover the
  // delay for the read slot to hold real history.
  assign w_out_valid = bus.sample_valid && w_armed && (r_fill >= w_delay_eff);
  // Delay 0 bypasses the RAM so the result never depends on read-during-write.
  assign w_out_data  = (w_delay_eff == '0) ? bus.sample_in : w_rd_data;

  delay_ram #(
    .DATA_W (SAMPLE_W),
    .ADDR_W (DELAY_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (bus.sample_valid),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.sample_in),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // State follows whether the history (including this cycle's write) covers
  // the delay in force after this cycle.
  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch
    // is inferred.
    w_state_next = r_state;
    if (w_armed) begin
      w_state_next = (w_fill_next >= w_delay_eff) ? RUN : FILL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_delay     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_out_valid;
      if (bus.delay_load) r_delay <= bus.delay_in;
      if (bus.sample_valid) begin
        r_wr_ptr <= r_wr_ptr + DELAY_W'(1);
        r_fill   <= w_fill_next;
      end
      if (w_out_valid) r_out <= w_out_data;
    end
  end

  assign bus.sample_out       = r_out;
  assign bus.sample_out_valid = r_out_valid;
  assign bus.debug_state      = {2'b00, r_state};

endmodule

// File: tb/tb_rx_delay_line.sv
module tb_rx_delay_line;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rx_delay_line_if bus ();

  rx_delay_line u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of accepted samples plus the delay in force.
  logic [15:0] hist [$];
  bit          m_loaded;
  int          m_delay;
  int          m_count;
  bit          exp_v;
  logic [15:0] exp_d;
  int          exp_s;

  task automatic model_clear();
    hist.delete();
    m_loaded = 1'b0;
    m_delay  = 0;
    m_count  = 0;
  endtask

  // Drives one cycle of inputs, predicts its outputs, then returns at the
  // following negedge where the registered outputs are observed.
  task automatic run_cycle(input bit ld, input int d, input bit v, input logic [15:0] s);
    int stored;
    bus.delay_load   = ld;
    bus.delay_in     = 8'(d);
    bus.sample_valid = v;
    bus.sample_in    = s;
    if (ld) begin
      m_loaded = 1'b1;
      m_delay  = d;
    end
    stored = (m_count > 255) ? 255 : m_count;
    exp_v  = v && m_loaded && (stored >= m_delay);
    if (exp_v) exp_d = (m_delay == 0) ? s : hist[hist.size() - m_delay];
    if (v) begin
      hist.push_back(s);
      if (hist.size() > 256) void'(hist.pop_front());
      m_count++;
    end
    stored = (m_count > 255) ? 255 : m_count;
    exp_s  = !m_loaded ? 0 : ((stored >= m_delay) ? 2 : 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.delay_load   = 1'b0;
    bus.delay_in     = '0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.sample_out_valid !== 1'b0 || bus.sample_out !== 16'h0 || bus.debug_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_state valid=%0b out=%h state=%0d expected 0/0000/0",
               bus.sample_out_valid, bus.sample_out, bus.debug_state);
    end
  endtask

  task automatic test_delay10();
    int first_idx;
    logic [15:0] first_val;
    first_idx = -1;
    first_val = '0;
    run_cycle(1'b1, 10, 1'b0, 16'h0);
    checks++;
    if (bus.debug_state !== 4'd1) begin
      errors++;
      $display("FAIL d10_load_state got=%0d expected=1", bus.debug_state);
    end
    for (int i = 1; i <= 30; i++) begin
      run_cycle(1'b0, 0, 1'b1, 16'(i));
      checks++;
      if (bus.sample_out_valid !== exp_v || (exp_v && bus.sample_out !== exp_d)) begin
        errors++;
        $display("FAIL d10_out in=%0d got v=%0b d=%h expected v=%0b d=%h",
                 i, bus.sample_out_valid, bus.sample_out, exp_v, exp_d);
      end
      checks++;
      if (bus.debug_state !== 4'(exp_s)) begin
        errors++;
        $display("FAIL d10_state in=%0d got=%0d expected=%0d", i, bus.debug_state, exp_s);
      end
      if (first_idx < 0 && bus.sample_out_valid === 1'b1) begin
        first_idx = i;
        first_val = bus.sample_out;
      end
    end
    checks++;
    if (first_idx != 11 || first_val !== 16'd1) begin
      errors++;
      $display("FAIL d10_first_valid got input=%0d value=%0d expected input=11 value=1",
               first_idx, first_val);
    end
  endtask

  task automatic test_delay0();
    logic [15:0] vals [2];
    vals[0] = 16'hA5A5;
    vals[1] = 16'h1234;
    apply_reset();
    run_cycle(1'b1, 0, 1'b0, 16'h0);
    checks++;
    if (bus.debug_state !== 4'd2) begin
      errors++;
      $display("FAIL d0_state got=%0d expected=2", bus.debug_state);
    end
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b0, 0, 1'b1, vals[i]);
      checks++;
      if (bus.sample_out_valid !== 1'b1 || bus.sample_out !== vals[i]) begin
        errors++;
        $display("FAIL d0_bypass idx=%0d got v=%0b d=%h expected v=1 d=%h",
                 i, bus.sample_out_valid, bus.sample_out, vals[i]);
      end
    end
  endtask

  task automatic test_change_delay();
    int first_idx;
    apply_reset();
    run_cycle(1'b1, 10, 1'b0, 16'h0);
    for (int i = 1; i <= 60; i++) begin
      run_cycle(i == 51, (i == 51) ? 3 : 0, 1'b1, 16'(i));
      checks++;
      if (bus.sample_out_valid !== exp_v || (exp_v && bus.sample_out !== exp_d)) begin
        errors++;
        $display("FAIL chg_out in=%0d got v=%0b d=%h expected v=%0b d=%h",
                 i, bus.sample_out_valid, bus.sample_out, exp_v, exp_d);
      end
      if (i == 51) begin
        checks++;
        if (bus.sample_out_valid !== 1'b1 || bus.sample_out !== 16'd48) begin
          errors++;
          $display("FAIL chg_same_cycle got v=%0b d=%0d expected v=1 d=48",
                   bus.sample_out_valid, bus.sample_out);
        end
      end
    end
    run_cycle(1'b1, 200, 1'b0, 16'h0);
    checks++;
    if (bus.debug_state !== 4'd1) begin
      errors++;
      $display("FAIL chg_to_fill got=%0d expected=1", bus.debug_state);
    end
    first_idx = -1;
    for (int i = 61; i <= 260; i++) begin
      run_cycle(1'b0, 0, 1'b1, 16'(i));
      checks++;
      if (bus.sample_out_valid !== exp_v || (exp_v && bus.sample_out !== exp_d)
          || bus.debug_state !== 4'(exp_s)) begin
        errors++;
        $display("FAIL chg200_out in=%0d got v=%0b d=%h s=%0d expected v=%0b d=%h s=%0d",
                 i, bus.sample_out_valid, bus.sample_out, bus.debug_state, exp_v, exp_d, exp_s);
      end
      if (first_idx < 0 && bus.sample_out_valid === 1'b1) first_idx = i;
    end
    checks++;
    if (first_idx != 201) begin
      errors++;
      $display("FAIL chg200_first got input=%0d expected=201", first_idx);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] base;
    int n_valid;
    base    = 16'($urandom);
    n_valid = 0;
    apply_reset();
    run_cycle(1'b1, 255, 1'b0, 16'h0);
    for (int i = 1; i <= 600; i++) begin
      run_cycle(1'b0, 0, 1'b1, base + 16'(i));
      checks++;
      if (bus.sample_out_valid !== exp_v || (exp_v && bus.sample_out !== exp_d)) begin
        errors++;
        $display("FAIL wrap_out in=%0d got v=%0b d=%h expected v=%0b d=%h",
                 i, bus.sample_out_valid, bus.sample_out, exp_v, exp_d);
      end
      if (bus.sample_out_valid === 1'b1) begin
        n_valid++;
        checks++;
        if (i < 256 || bus.sample_out !== base + 16'(i - 255)) begin
          errors++;
          $display("FAIL wrap_rule in=%0d got=%h expected=%h",
                   i, bus.sample_out, base + 16'(i - 255));
        end
      end
    end
    checks++;
    if (n_valid != 345) begin
      errors++;
      $display("FAIL wrap_count got=%0d expected=345", n_valid);
    end
  endtask

  task automatic test_gaps();
    int n_in;
    int n_out;
    n_in  = 0;
    n_out = 0;
    apply_reset();
    run_cycle(1'b1, 5, 1'b0, 16'h0);
    for (int i = 0; i < 60; i++) begin
      bit v;
      v = (i % 3) == 0;
      if (v) n_in++;
      run_cycle(1'b0, 0, v, 16'($urandom));
      checks++;
      if (bus.sample_out_valid !== exp_v || (exp_v && bus.sample_out !== exp_d)) begin
        errors++;
        $display("FAIL gap_out cyc=%0d got v=%0b d=%h expected v=%0b d=%h",
                 i, bus.sample_out_valid, bus.sample_out, exp_v, exp_d);
      end
      if (bus.sample_out_valid === 1'b1) n_out++;
    end
    checks++;
    if (n_out != n_in - 5) begin
      errors++;
      $display("FAIL gap_count got=%0d expected=%0d", n_out, n_in - 5);
    end
  endtask

  task automatic test_async_reset();
    int n_bad;
    apply_reset();
    run_cycle(1'b1, 4, 1'b0, 16'h0);
    for (int i = 1; i <= 20; i++) run_cycle(1'b0, 0, 1'b1, 16'(i + 100));
    checks++;
    if (bus.sample_out_valid !== 1'b1 || bus.debug_state !== 4'd2) begin
      errors++;
      $display("FAIL arst_pre got v=%0b s=%0d expected v=1 s=2",
               bus.sample_out_valid, bus.debug_state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sample_out_valid !== 1'b0 || bus.sample_out !== 16'h0 || bus.debug_state !== 4'd0) begin
      errors++;
      $display("FAIL arst_immediate got v=%0b d=%h s=%0d expected 0/0000/0",
               bus.sample_out_valid, bus.sample_out, bus.debug_state);
    end
    bus.sample_valid = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    n_bad = 0;
    for (int i = 0; i < 100; i++) begin
      run_cycle(1'b0, 0, 1'b1, 16'($urandom));
      if (bus.sample_out_valid !== exp_v || bus.debug_state !== 4'(exp_s)) n_bad++;
    end
    checks++;
    if (n_bad != 0) begin
      errors++;
      $display("FAIL arst_idle bad_cycles=%0d expected=0 (no valid, state 0)", n_bad);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      bit ld;
      int d;
      ld = ($urandom_range(0, 19) == 0);
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
      run_cycle(ld, d, $urandom_range(0, 3) != 0, 16'($urandom));
      checks++;
      if (bus.sample_out_valid !== exp_v || (exp_v && bus.sample_out !== exp_d)
          || bus.debug_state !== 4'(exp_s)) begin
        errors++;
        $display("FAIL rand_out cyc=%0d got v=%0b d=%h s=%0d expected v=%0b d=%h s=%0d",
                 i, bus.sample_out_valid, bus.sample_out, bus.debug_state, exp_v, exp_d, exp_s);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_delay10();
    test_delay0();
    test_change_delay();
    test_wrap();
    test_gaps();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
